sdio_fbr_bank: RTL and testbench
================================

// Module: sdio_fbr_bank
// PURPOSE
//  Multi-function FBR bank: one Function Basic Register set for each of functions 1..NUM_FUNCS at CIA 0x100*n.
//  Adds a CSA window (0x0C-0x0F) with an auto-increment pointer, bridged to external CSA storage by a req/ack handshake.
//  Enforces a block-size limit. Reports completion through o_data_rdy.
//  Sits in the CIA between the CMD52/CMD53 decoder and the per-function cores.
// PARAMETERS
//  NUM_FUNCS      7            functions implemented, 1..7
//  FUNC_TYPES     28'h0        packed 4b standard interface code per function, func n at [4n-1:4n-4]
//  CSA_SUPPORT    7'h00        bit n-1 set: function n supports CSA
//  CIS_BASE       24'h001000   CIS pointer of function 1
//  CIS_STRIDE     24'h000100   CIS pointer step per function
//  DEF_BLK_SIZE   256          reset block size, all functions
//  MAX_BLK_SIZE   2048         largest accepted block size
// PORTS
//  clk            in   1            system clock
//  rst            in   1            synchronous reset, ACTIVE-LOW (0 = reset)
//  i_activate     in   1            bank selected by CIA decoder
//  i_write_flag   in   1            1 = write, 0 = read; sampled with i_data_stb
//  i_address      in   17           CIA byte address
//  i_data_stb     in   1            single-cycle access strobe
//  i_data_in      in   8            write data
//  o_data_out     out  8            read data, valid while o_data_rdy = 1
//  o_data_rdy     out  1            1-cycle pulse: access complete
//  o_busy         out  1            CSA transfer in flight
//  o_err          out  1            1-cycle pulse with o_data_rdy: access rejected
//  o_csa_en       out  NUM_FUNCS    per-function CSA enable
//  o_pwr_sel      out  NUM_FUNCS    per-function EPS (low-power select)
//  o_block_size   out  16*NUM_FUNCS packed block sizes, func n at [16n-1:16n-16]
//  o_csa_req      out  1            CSA request, held until ack
//  o_csa_we       out  1            1 = CSA write
//  o_csa_func     out  3            target function number
//  o_csa_addr     out  24           CSA byte address
//  o_csa_wdata    out  8            CSA write data
//  i_csa_ack      in   1            CSA transfer done
//  i_csa_rdata    in   8            CSA read data, valid with ack
// BEHAVIOUR
//  Reset (rst = 0 at clk edge):
//   - o_data_out = 0; o_data_rdy/o_busy/o_err/o_csa_req/o_csa_we = 0.
//   - o_csa_en = 0; o_pwr_sel = 0; every block size = DEF_BLK_SIZE; all CSA pointers = 0.
//   - Reset aborts any CSA transfer in flight: o_csa_req drops at the same edge and no o_data_rdy follows.
//  Address decode:
//   - Function n = i_address[10:8]; offset = i_address[7:0].
//   - n = 0, n > NUM_FUNCS, or offset > 0x11: reads return 0x00, writes are dropped, o_err = 0.
//  Register map (per function):
//   - 0x00: {csa_en, CSA_SUPPORT[n-1], 2'b0, FUNC_TYPES[n]}. Bit7 is writable only if CSA is supported.
//   - 0x01: 0x00.
//   - 0x02: {6'b0, pwr_sel, 1'b1}. Bit1 is writable.
//   - 0x03-0x08: 0x00.
//   - 0x09/0x0A/0x0B: CIS pointer bytes LSB..MSB, = CIS_BASE + (n-1)*CIS_STRIDE.
//   - 0x0C/0x0D/0x0E: CSA pointer bytes LSB..MSB, read/write.
//   - 0x0F: CSA data window.
//   - 0x10/0x11: block size LSB/MSB.
//  Register access:
//   - Strobe with i_activate = 1 and FSM IDLE.
//   - o_data_rdy is pulsed 1 cycle after the strobe; read data is presented in that same cycle.
//  Block size writes:
//   - The new 16b value = written byte merged with the other stored byte.
//   - If the new value is 0 or > MAX_BLK_SIZE: write discarded, o_err pulses with o_data_rdy.
//  CSA window access (offset 0x0F):
//   - If csa_en[n] = 0: read returns 0x00, write is dropped, o_err = 1, rdy 1 cycle after the strobe; no request is issued.
//   - Otherwise FSM goes IDLE -> CSA_REQ: o_csa_req is asserted 1 cycle after the strobe.
//   - While in CSA_REQ, o_csa_func/o_csa_addr/o_csa_we/o_csa_wdata are held stable; o_busy = 1.
//   - On i_csa_ack: req drops, o_data_out = i_csa_rdata (reads), state -> DONE.
//   - DONE: o_data_rdy pulse; the pointer increments by 1 and wraps 0xFFFFFF -> 0x000000. -> IDLE.
//   - Minimum latency is 3 cycles (ack in the first cycle of req). There is no timeout.
//  Simultaneous/overlap:
//   - Strobes arriving while o_busy = 1 are ignored: no rdy, no state change.
//   - i_csa_ack outside CSA_REQ is ignored.
//   - A pointer write and a CSA access to the same function cannot overlap (they are serialised by o_busy).
// TESTING
//  1. Reset, then read fn3 0x10/0x11 -> 0x00/0x01. Read fn2 0x0A -> 0x11 (CIS 0x001100). rdy 1 cycle after each strobe.
//  2. Write fn1 0x11 = 0x08 (2048) -> accepted. Write 0x10 = 0x01 (2049) -> o_err = 1, size stays 2048.
//  3. CSA_SUPPORT = 7'h01. Write fn1 0x00 bit7 = 1, pointer = 0xFFFFFF, read 0x0F with ack after 2 cycles ->
//     req on 0xFFFFFF, data = i_csa_rdata, pointer = 0x000000.
//  4. Write fn2 0x0F = 0x5A with csa_en[2] = 0 -> o_csa_req never asserts, o_err = 1, rdy 1 cycle later.
//  5. Strobe issued while o_busy = 1 -> ignored. Pull rst = 0 mid-request -> req drops the same edge, no rdy pulse, all registers at defaults.
//  6. Access fn0 and fn7 with NUM_FUNCS = 2, and offset 0x12 -> reads 0x00, writes dropped, no o_err.

Source files
------------

// File: rtl/sdio_fbr_bank.sv
// SDIO Function Basic Register bank for functions 1..NUM_FUNCS, including a CSA
// data window that is bridged to external storage through a req/ack handshake.
module sdio_fbr_bank #(
    parameter int          NUM_FUNCS    = 7,
    parameter logic [27:0] FUNC_TYPES   = 28'h0,
    parameter logic [6:0]  CSA_SUPPORT  = 7'h00,
    parameter logic [23:0] CIS_BASE     = 24'h001000,
    parameter logic [23:0] CIS_STRIDE   = 24'h000100,
    parameter int          DEF_BLK_SIZE = 256,
    parameter int          MAX_BLK_SIZE = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_activate,
    input  logic                   i_write_flag,
    input  logic [16:0]            i_address,
    input  logic                   i_data_stb,
    input  logic [7:0]             i_data_in,
    output logic [7:0]             o_data_out,
    output logic                   o_data_rdy,
    output logic                   o_busy,
    output logic                   o_err,
    output logic [NUM_FUNCS-1:0]   o_csa_en,
    output logic [NUM_FUNCS-1:0]   o_pwr_sel,
    output logic [16*NUM_FUNCS-1:0] o_block_size,
    output logic                   o_csa_req,
    output logic                   o_csa_we,
    output logic [2:0]             o_csa_func,
    output logic [23:0]            o_csa_addr,
    output logic [7:0]             o_csa_wdata,
    input  logic                   i_csa_ack,
    input  logic [7:0]             i_csa_rdata
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_CSA_REQ = 2'd1;
    localparam logic [1:0]  ST_DONE    = 2'd2;
    localparam logic [15:0] DEF_BLK    = 16'(DEF_BLK_SIZE);
    localparam logic [15:0] MAX_BLK    = 16'(MAX_BLK_SIZE);

    logic [1:0]           state_q, state_d;
    logic [NUM_FUNCS-1:0] csa_en_q;
    logic [NUM_FUNCS-1:0] pwr_sel_q;
    logic [15:0]          blk_size_q [NUM_FUNCS];
    logic [23:0]          csa_ptr_q  [NUM_FUNCS];

    logic [2:0]  fn, fn_idx;
    logic [7:0]  off, rd_data;
    logic        fn_valid, reg_hit, accept, csa_go;
    logic        cur_en, cur_pwr, cur_sup;
    logic [3:0]  cur_type;
    logic [15:0] cur_blk, blk_new;
    logic [23:0] cur_ptr, cis_ptr;
    logic        blk_wr, blk_bad;
    logic        unused_addr;

    assign fn          = i_address[10:8];
    assign off         = i_address[7:0];
    assign fn_idx      = fn - 3'd1;
    assign fn_valid    = (fn != 3'd0) && (int'(fn) <= NUM_FUNCS);
    assign reg_hit     = fn_valid && (off <= 8'h11);
    assign accept      = i_data_stb && i_activate && (state_q == ST_IDLE);
    assign csa_go      = accept && reg_hit && (off == 8'h0F) && cur_en;
    assign cis_ptr     = CIS_BASE + CIS_STRIDE * {21'd0, fn_idx};
    assign blk_wr      = (off == 8'h10) || (off == 8'h11);
    assign blk_new     = off[0] ? {i_data_in, cur_blk[7:0]} : {cur_blk[15:8], i_data_in};
    assign blk_bad     = (blk_new == 16'd0) || (blk_new > MAX_BLK);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_csa_en    = csa_en_q;
    assign o_pwr_sel   = pwr_sel_q;
    assign unused_addr = &{1'b0, i_address[16:11]};

    for (genvar g = 0; g < NUM_FUNCS; g++) begin : g_blk_out
        assign o_block_size[16*g +: 16] = blk_size_q[g];
    end

    // Select the addressed function's state, then build the read byte from it.
    always_comb begin
        cur_en   = 1'b0;
        cur_pwr  = 1'b0;
        cur_sup  = 1'b0;
        cur_type = 4'h0;
        cur_blk  = 16'h0;
        cur_ptr  = 24'h0;
        for (int f = 0; f < NUM_FUNCS; f++) begin
            if (fn_idx == 3'(f)) begin
                cur_en   = csa_en_q[f];
                cur_pwr  = pwr_sel_q[f];
                cur_sup  = CSA_SUPPORT[f];
                cur_type = FUNC_TYPES[4*f +: 4];
                cur_blk  = blk_size_q[f];
                cur_ptr  = csa_ptr_q[f];
            end
        end
        case (off)
            8'h00:   rd_data = {cur_en, cur_sup, 2'b00, cur_type};
            8'h02:   rd_data = {6'b0, cur_pwr, 1'b1};
            8'h09:   rd_data = cis_ptr[7:0];
            8'h0A:   rd_data = cis_ptr[15:8];
            8'h0B:   rd_data = cis_ptr[23:16];
            8'h0C:   rd_data = cur_ptr[7:0];
            8'h0D:   rd_data = cur_ptr[15:8];
            8'h0E:   rd_data = cur_ptr[23:16];
            8'h10:   rd_data = cur_blk[7:0];
            8'h11:   rd_data = cur_blk[15:8];
            default: rd_data = 8'h00;
        endcase
        if (!fn_valid) begin
            rd_data = 8'h00;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (csa_go) state_d = ST_CSA_REQ;
            ST_CSA_REQ: if (i_csa_ack) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all updates see pre-edge values;
    // the per-function arrays are reset too because software relies on defaults.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            o_data_out  <= 8'h00;
            o_data_rdy  <= 1'b0;
            o_err       <= 1'b0;
            o_csa_req   <= 1'b0;
            o_csa_we    <= 1'b0;
            o_csa_func  <= 3'd0;
            o_csa_addr  <= 24'h0;
            o_csa_wdata <= 8'h00;
            csa_en_q    <= '0;
            pwr_sel_q   <= '0;
            for (int f = 0; f < NUM_FUNCS; f++) begin
                blk_size_q[f] <= DEF_BLK;
                csa_ptr_q[f]  <= 24'h0;
            end
        end else begin
            state_q    <= state_d;
            o_data_rdy <= 1'b0;
            o_err      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (csa_go) begin
                        o_csa_req   <= 1'b1;
                        o_csa_we    <= i_write_flag;
                        o_csa_func  <= fn;
                        o_csa_addr  <= cur_ptr;
                        o_csa_wdata <= i_data_in;
                    end else if (accept) begin
                        o_data_rdy <= 1'b1;
                        o_data_out <= i_write_flag ? 8'h00 : rd_data;
                        o_err      <= reg_hit && ((off == 8'h0F) ||
                                                  (i_write_flag && blk_wr && blk_bad));
                        if (reg_hit && i_write_flag) begin
                            for (int f = 0; f < NUM_FUNCS; f++) begin
                                if (fn_idx == 3'(f)) begin
                                    case (off)
                                        8'h00: if (CSA_SUPPORT[f]) csa_en_q[f] <= i_data_in[7];
                                        8'h02: pwr_sel_q[f] <= i_data_in[1];
                                        8'h0C: csa_ptr_q[f][7:0]   <= i_data_in;
                                        8'h0D: csa_ptr_q[f][15:8]  <= i_data_in;
                                        8'h0E: csa_ptr_q[f][23:16] <= i_data_in;
                                        8'h10, 8'h11: if (!blk_bad) blk_size_q[f] <= blk_new;
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end
                end
                ST_CSA_REQ: begin
                    if (i_csa_ack) begin
                        o_csa_req  <= 1'b0;
                        o_data_out <= o_csa_we ? 8'h00 : i_csa_rdata;
                    end
                end
                ST_DONE: begin
                    o_data_rdy <= 1'b1;
                    for (int f = 0; f < NUM_FUNCS; f++) begin
                        if (o_csa_func == 3'(f + 1)) csa_ptr_q[f] <= csa_ptr_q[f] + 24'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_fbr_bank.sv
// Scoreboard bench for sdio_fbr_bank: expected completions are queued at strobe
// time and retired by a monitor on every o_data_rdy pulse.
module tb_sdio_fbr_bank;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       err;
        logic       chk_data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_activate = 1'b0, i_write_flag = 1'b0, i_data_stb = 1'b0;
    logic [16:0] i_address = '0;
    logic [7:0]  i_data_in = '0;
    logic        i_csa_ack = 1'b0;
    logic [7:0]  i_csa_rdata = '0;

    logic [7:0]   o_data_out;
    logic         o_data_rdy, o_busy, o_err;
    logic [6:0]   o_csa_en, o_pwr_sel;
    logic [111:0] o_block_size;
    logic         o_csa_req, o_csa_we;
    logic [2:0]   o_csa_func;
    logic [23:0]  o_csa_addr;
    logic [7:0]   o_csa_wdata;

    logic [7:0]  d2_data;
    logic        d2_rdy, d2_busy, d2_err;
    logic [1:0]  d2_csa_en, d2_pwr_sel;
    logic [31:0] d2_block_size;
    logic        d2_csa_req, d2_csa_we;
    logic [2:0]  d2_csa_func;
    logic [23:0] d2_csa_addr;
    logic [7:0]  d2_csa_wdata;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    logic req_seen = 1'b0;
    logic ack_en = 1'b1;
    int   ack_delay = 1;
    int   req_age = 0;
    logic [7:0] ack_data = 8'h00;

    always #5 clk = ~clk;

    sdio_fbr_bank #(
        .NUM_FUNCS(7), .FUNC_TYPES(28'h0000321), .CSA_SUPPORT(7'h01)
    ) dut (
        .clk(clk), .rst(rst), .i_activate(i_activate), .i_write_flag(i_write_flag),
        .i_address(i_address), .i_data_stb(i_data_stb), .i_data_in(i_data_in),
        .o_data_out(o_data_out), .o_data_rdy(o_data_rdy), .o_busy(o_busy), .o_err(o_err),
        .o_csa_en(o_csa_en), .o_pwr_sel(o_pwr_sel), .o_block_size(o_block_size),
        .o_csa_req(o_csa_req), .o_csa_we(o_csa_we), .o_csa_func(o_csa_func),
        .o_csa_addr(o_csa_addr), .o_csa_wdata(o_csa_wdata),
        .i_csa_ack(i_csa_ack), .i_csa_rdata(i_csa_rdata)
    );

    sdio_fbr_bank #(.NUM_FUNCS(2)) dut2 (
        .clk(clk), .rst(rst), .i_activate(i_activate), .i_write_flag(i_write_flag),
        .i_address(i_address), .i_data_stb(i_data_stb), .i_data_in(i_data_in),
        .o_data_out(d2_data), .o_data_rdy(d2_rdy), .o_busy(d2_busy), .o_err(d2_err),
        .o_csa_en(d2_csa_en), .o_pwr_sel(d2_pwr_sel), .o_block_size(d2_block_size),
        .o_csa_req(d2_csa_req), .o_csa_we(d2_csa_we), .o_csa_func(d2_csa_func),
        .o_csa_addr(d2_csa_addr), .o_csa_wdata(d2_csa_wdata),
        .i_csa_ack(i_csa_ack), .i_csa_rdata(i_csa_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // CSA target model: acks ack_delay cycles after the request is first seen.
    always @(negedge clk) begin
        if (o_csa_req && ack_en) begin
            req_age++;
            if (req_age == ack_delay) begin
                i_csa_ack   = 1'b1;
                i_csa_rdata = ack_data;
            end else begin
                i_csa_ack = 1'b0;
            end
        end else begin
            i_csa_ack = 1'b0;
            req_age   = 0;
        end
    end

    // Completion monitor: retires one scoreboard entry per rdy pulse.
    always @(negedge clk) begin
        exp_t e;
        if (o_csa_req) req_seen = 1'b1;
        if (o_data_rdy) begin
            if (sb_q.size() == 0) begin
                check("spurious_rdy", 32'(o_data_rdy), 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.chk_data) check({e.tag, "_data"}, 32'(o_data_out), 32'(e.data));
                check({e.tag, "_err"}, 32'(o_err), 32'(e.err));
            end
        end else if (o_err) begin
            check("err_without_rdy", 32'(o_err), 32'd0);
        end
    end

    task automatic strobe(input logic [2:0] fn, input logic [7:0] off,
                          input logic wr, input logic [7:0] d);
        @(posedge clk);
        #1;
        i_activate   = 1'b1;
        i_data_stb   = 1'b1;
        i_write_flag = wr;
        i_address    = {6'b0, fn, off};
        i_data_in    = d;
        @(posedge clk);
        #1;
        i_activate = 1'b0;
        i_data_stb = 1'b0;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] d, input logic err,
                            input logic chk_d);
        exp_t e;
        e.tag = tag; e.data = d; e.err = err; e.chk_data = chk_d;
        sb_q.push_back(e);
    endtask

    task automatic reg_access(input string tag, input logic [2:0] fn, input logic [7:0] off,
                              input logic wr, input logic [7:0] d,
                              input logic [7:0] exp_d, input logic exp_e);
        int k;
        push_exp(tag, exp_d, exp_e, !wr);
        strobe(fn, off, wr, d);
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (o_data_rdy) break;
        end
        check({tag, "_lat"}, 32'(k), 32'd1);
    endtask

    task automatic csa_access(input string tag, input logic wr, input logic [7:0] wdata,
                              input logic [7:0] rdata, input int delay,
                              input logic [23:0] exp_addr, input int exp_lat);
        int k;
        ack_delay = delay;
        ack_data  = rdata;
        push_exp(tag, rdata, 1'b0, !wr);
        strobe(3'd1, 8'h0F, wr, wdata);
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_csa_req) begin
                check({tag, "_addr"}, 32'(o_csa_addr), 32'(exp_addr));
                check({tag, "_func"}, 32'(o_csa_func), 32'd1);
                check({tag, "_we"}, 32'(o_csa_we), 32'(wr));
                check({tag, "_busy"}, 32'(o_busy), 32'd1);
                if (wr) check({tag, "_wdata"}, 32'(o_csa_wdata), 32'(wdata));
            end
            if (o_data_rdy) break;
        end
        check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(negedge clk);
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_defaults(input string tag);
        check({tag, "_rdy"}, 32'(o_data_rdy), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_req"}, 32'(o_csa_req), 32'd0);
        check({tag, "_csa_en"}, 32'(o_csa_en), 32'd0);
        check({tag, "_pwr"}, 32'(o_pwr_sel), 32'd0);
        for (int f = 0; f < 7; f++) check({tag, "_blk"}, 32'(o_block_size[16*f +: 16]), 32'h0100);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_defaults("rst");
        check("rst_data", 32'(o_data_out), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // defaults and CIS pointers
        reg_access("f3_blk_lo", 3'd3, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("f3_blk_hi", 3'd3, 8'h11, 1'b0, 8'h00, 8'h01, 1'b0);
        reg_access("f2_cis_lo", 3'd2, 8'h09, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("f2_cis_mid", 3'd2, 8'h0A, 1'b0, 8'h00, 8'h11, 1'b0);
        reg_access("f2_cis_hi", 3'd2, 8'h0B, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("f7_cis_mid", 3'd7, 8'h0A, 1'b0, 8'h00, 8'h16, 1'b0);
        reg_access("f1_r00", 3'd1, 8'h00, 1'b0, 8'h00, 8'h41, 1'b0);
        reg_access("f2_r00", 3'd2, 8'h00, 1'b0, 8'h00, 8'h02, 1'b0);
        reg_access("f3_r00", 3'd3, 8'h00, 1'b0, 8'h00, 8'h03, 1'b0);
        reg_access("f1_r02", 3'd1, 8'h02, 1'b0, 8'h00, 8'h01, 1'b0);
        reg_access("f4_r05", 3'd4, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0);

        // block size limits
        reg_access("blk_2048", 3'd1, 8'h11, 1'b1, 8'h08, 8'h00, 1'b0);
        reg_access("blk_2049", 3'd1, 8'h10, 1'b1, 8'h01, 8'h00, 1'b1);
        reg_access("blk_rd_lo", 3'd1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("blk_rd_hi", 3'd1, 8'h11, 1'b0, 8'h00, 8'h08, 1'b0);
        check("blk_f1_out", 32'(o_block_size[15:0]), 32'h0800);
        reg_access("blk_zero", 3'd1, 8'h11, 1'b1, 8'h00, 8'h00, 1'b1);
        reg_access("blk_rd_hi2", 3'd1, 8'h11, 1'b0, 8'h00, 8'h08, 1'b0);
        reg_access("blk_f2_1ff", 3'd2, 8'h10, 1'b1, 8'hFF, 8'h00, 1'b0);
        check("blk_f2_out", 32'(o_block_size[31:16]), 32'h01FF);
        reg_access("blk_f3_2304", 3'd3, 8'h11, 1'b1, 8'h09, 8'h00, 1'b1);
        check("blk_f3_out", 32'(o_block_size[47:32]), 32'h0100);

        // EPS and CSA enable writability
        reg_access("pwr_wr", 3'd1, 8'h02, 1'b1, 8'hFF, 8'h00, 1'b0);
        reg_access("pwr_rd", 3'd1, 8'h02, 1'b0, 8'h00, 8'h03, 1'b0);
        check("pwr_out", 32'(o_pwr_sel), 32'h01);
        reg_access("f2_en_wr", 3'd2, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0);
        reg_access("f2_en_rd", 3'd2, 8'h00, 1'b0, 8'h00, 8'h02, 1'b0);
        check("f2_en_out", 32'(o_csa_en), 32'h00);

        // CSA window with pointer wrap
        reg_access("f1_en_wr", 3'd1, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0);
        check("f1_en_out", 32'(o_csa_en), 32'h01);
        reg_access("f1_en_rd", 3'd1, 8'h00, 1'b0, 8'h00, 8'hC1, 1'b0);
        reg_access("ptr_w0", 3'd1, 8'h0C, 1'b1, 8'hFF, 8'h00, 1'b0);
        reg_access("ptr_w1", 3'd1, 8'h0D, 1'b1, 8'hFF, 8'h00, 1'b0);
        reg_access("ptr_w2", 3'd1, 8'h0E, 1'b1, 8'hFF, 8'h00, 1'b0);
        reg_access("ptr_r1", 3'd1, 8'h0D, 1'b0, 8'h00, 8'hFF, 1'b0);
        csa_access("csa_rd", 1'b0, 8'h00, 8'hA5, 2, 24'hFFFFFF, 4);
        reg_access("wrap_r0", 3'd1, 8'h0C, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("wrap_r1", 3'd1, 8'h0D, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("wrap_r2", 3'd1, 8'h0E, 1'b0, 8'h00, 8'h00, 1'b0);
        csa_access("csa_wr", 1'b1, 8'h3C, 8'h00, 1, 24'h000000, 3);
        reg_access("inc_r0", 3'd1, 8'h0C, 1'b0, 8'h00, 8'h01, 1'b0);

        // CSA window on a disabled function
        req_seen = 1'b0;
        reg_access("f2_csa_wr", 3'd2, 8'h0F, 1'b1, 8'h5A, 8'h00, 1'b1);
        reg_access("f2_csa_rd", 3'd2, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        check("f2_no_req", 32'(req_seen), 32'd0);

        // strobes while busy are ignored
        ack_delay = 6;
        ack_data  = 8'h77;
        push_exp("busy_csa", 8'h77, 1'b0, 1'b1);
        strobe(3'd1, 8'h0F, 1'b0, 8'h00);
        strobe(3'd3, 8'h10, 1'b0, 8'h00);
        strobe(3'd1, 8'h02, 1'b1, 8'h00);
        @(negedge clk);
        check("busy_flag", 32'(o_busy), 32'd1);
        drain("busy_drain");
        reg_access("busy_pwr", 3'd1, 8'h02, 1'b0, 8'h00, 8'h03, 1'b0);
        reg_access("busy_ptr", 3'd1, 8'h0C, 1'b0, 8'h00, 8'h02, 1'b0);

        // reset aborts an in-flight request
        ack_en = 1'b0;
        strobe(3'd1, 8'h0F, 1'b0, 8'h00);
        @(negedge clk);
        check("abort_req_up", 32'(o_csa_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_defaults("abort");
        @(posedge clk);
        #1 rst = 1'b1;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        reg_access("abort_ptr", 3'd1, 8'h0C, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("abort_blk", 3'd1, 8'h11, 1'b0, 8'h00, 8'h01, 1'b0);
        reg_access("abort_pwr", 3'd1, 8'h02, 1'b0, 8'h00, 8'h01, 1'b0);
        reg_access("abort_en", 3'd1, 8'h00, 1'b0, 8'h00, 8'h41, 1'b0);

        // out-of-range functions and offsets
        reg_access("f0_rd", 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("f0_wr", 3'd0, 8'h10, 1'b1, 8'h00, 8'h00, 1'b0);
        reg_access("o12_rd", 3'd1, 8'h12, 1'b0, 8'h00, 8'h00, 1'b0);
        reg_access("o12_wr", 3'd1, 8'h12, 1'b1, 8'hAA, 8'h00, 1'b0);
        reg_access("off_ff", 3'd1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
        push_exp("m_f7_rd", 8'h00, 1'b0, 1'b1);
        strobe(3'd7, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        check("d2_f7_rdy", 32'(d2_rdy), 32'd1);
        check("d2_f7_data", 32'(d2_data), 32'd0);
        check("d2_f7_err", 32'(d2_err), 32'd0);
        push_exp("m_f7_wr", 8'h00, 1'b0, 1'b0);
        strobe(3'd7, 8'h02, 1'b1, 8'h02);
        @(negedge clk);
        check("d2_f7w_rdy", 32'(d2_rdy), 32'd1);
        check("d2_f7w_err", 32'(d2_err), 32'd0);
        check("d2_pwr", 32'(d2_pwr_sel), 32'd0);
        push_exp("m_f2_blk", 8'h01, 1'b0, 1'b1);
        strobe(3'd2, 8'h11, 1'b0, 8'h00);
        @(negedge clk);
        check("d2_f2_rdy", 32'(d2_rdy), 32'd1);
        check("d2_f2_data", 32'(d2_data), 32'h01);

        repeat (5) @(negedge clk);
        drain("final_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
